// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and constants for the truth-table sweeper and its settle timer.
package truth_table_sweeper_pkg;

   localparam int unsigned VEC_BITS = 4;
   localparam int unsigned TABLE_W  = 16;
   localparam logic [VEC_BITS-1:0] LAST_IDX = 4'd15;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StSettle = 2'd1,
      StSample = 2'd2,
      StDone   = 2'd3
   } state_t;

   // States in which the function block is enabled and sees the current vector.
   function automatic logic drives_vector(input state_t s);
      return (s == StSettle) || (s == StSample);
   endfunction

endpackage

// File: rtl/truth_table_sweeper_settle_timer.sv
// Down-counter that holds each vector for SETTLE_CYCLES cycles before sampling.
module truth_table_sweeper_settle_timer #(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic count,
   output logic expired
);

   localparam int unsigned W = $clog2(SETTLE_CYCLES + 1);
   // Loaded on SETTLE entry; the cycle in which it reads zero is the last settle cycle.
   localparam logic [W-1:0] LOAD_VAL = W'(SETTLE_CYCLES - 1);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = LOAD_VAL;
      end else if (count && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// On-chip self-check sequencer: sweeps all 16 vectors of a 4-input function block,
// captures f into a truth table and compares it against a latched golden table.
module truth_table_sweeper
   import truth_table_sweeper_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   input  logic [15:0] expected,
   input  logic        f_in,
   output logic        en_out,
   output logic        a_out,
   output logic        b_out,
   output logic        c_out,
   output logic        d_out,
   output logic        busy,
   output logic        done,
   output logic [15:0] table_out,
   output logic        mismatch,
   output logic [4:0]  err_count,
   output logic [3:0]  first_err_idx
);

   state_t state_q, state_d;

   logic [VEC_BITS-1:0] idx_q, idx_d;
   logic [TABLE_W-1:0]  exp_q, exp_d;
   logic [TABLE_W-1:0]  table_d;
   logic [4:0]          err_d;
   logic [VEC_BITS-1:0] first_d;
   logic                mismatch_d;
   logic                en_d, busy_d, done_d;
   logic [VEC_BITS-1:0] vec_d;

   logic timer_load, timer_count, timer_expired;

   assign timer_load  = (state_d == StSettle) && (state_q != StSettle);
   assign timer_count = (state_q == StSettle);

   truth_table_sweeper_settle_timer #(
      .SETTLE_CYCLES(SETTLE_CYCLES)
   ) u_settle_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (timer_load),
      .count  (timer_count),
      .expired(timer_expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (start && !abort) state_d = StSettle;
         end
         StSettle: begin
            if (abort)              state_d = StIdle;
            else if (timer_expired) state_d = StSample;
         end
         StSample: begin
            if (abort)                  state_d = StIdle;
            else if (idx_q == LAST_IDX) state_d = StDone;
            else                        state_d = StSettle;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Datapath and output next-state; outputs are registered aligned with state_q.
   always_comb begin
      idx_d      = idx_q;
      exp_d      = exp_q;
      table_d    = table_out;
      err_d      = err_count;
      first_d    = first_err_idx;
      mismatch_d = mismatch;

      if ((state_q == StIdle) && (state_d == StSettle)) begin
         idx_d      = '0;
         exp_d      = expected;
         table_d    = '0;
         err_d      = '0;
         first_d    = '0;
         mismatch_d = 1'b0;
      end

      // Abort leaves state_d at StIdle, which suppresses this capture.
      if ((state_q == StSample) && (state_d != StIdle)) begin
         table_d[idx_q] = f_in;
         if (f_in != exp_q[idx_q]) begin
            err_d = err_count + 5'd1;
            if (err_count == 5'd0) first_d = idx_q;
         end
         if (idx_q != LAST_IDX) idx_d = idx_q + 4'd1;
      end

      if ((state_q == StSample) && (state_d == StDone)) begin
         mismatch_d = (err_d != 5'd0);
      end

      en_d   = drives_vector(state_d);
      busy_d = en_d;
      done_d = (state_d == StDone);
      vec_d  = en_d ? idx_d : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q                         <= '0;
         exp_q                         <= '0;
         table_out                     <= '0;
         err_count                     <= '0;
         first_err_idx                 <= '0;
         mismatch                      <= 1'b0;
         en_out                        <= 1'b0;
         busy                          <= 1'b0;
         done                          <= 1'b0;
         {a_out, b_out, c_out, d_out}  <= '0;
      end else begin
         idx_q                         <= idx_d;
         exp_q                         <= exp_d;
         table_out                     <= table_d;
         err_count                     <= err_d;
         first_err_idx                 <= first_d;
         mismatch                      <= mismatch_d;
         en_out                        <= en_d;
         busy                          <= busy_d;
         done                          <= done_d;
         {a_out, b_out, c_out, d_out}  <= vec_d;
      end
   end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper with a behavioural function block driving f_in.
module tb_truth_table_sweeper;

   localparam int S = 2;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic [15:0] expected;
   logic        f_in;
   logic        en_out, a_out, b_out, c_out, d_out;
   logic        busy, done, mismatch;
   logic [15:0] table_out;
   logic [4:0]  err_count;
   logic [3:0]  first_err_idx;

   int n_vec = 0;
   int n_err = 0;
   int mode  = 0;

   logic [3:0] vec;
   assign vec = {a_out, b_out, c_out, d_out};

   // mode 0: constant 0, 1: AND, 2: XOR, 3: XOR with vector 5 inverted
   always_comb begin
      f_in = 1'b0;
      if (en_out) begin
         case (mode)
            1:       f_in = &vec;
            2:       f_in = ^vec;
            3:       f_in = (^vec) ^ (vec == 4'd5);
            default: f_in = 1'b0;
         endcase
      end
   end

   truth_table_sweeper #(
      .SETTLE_CYCLES(S)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .abort        (abort),
      .expected     (expected),
      .f_in         (f_in),
      .en_out       (en_out),
      .a_out        (a_out),
      .b_out        (b_out),
      .c_out        (c_out),
      .d_out        (d_out),
      .busy         (busy),
      .done         (done),
      .table_out    (table_out),
      .mismatch     (mismatch),
      .err_count    (err_count),
      .first_err_idx(first_err_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, expv);
      end
   endtask

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk1(tag, en_out | busy | done | mismatch, 1'b0);
      chk16(tag, 16'(vec), 16'h0);
      chk16(tag, table_out, 16'h0);
      chk16(tag, 16'(err_count), 16'h0);
      chk16(tag, 16'(first_err_idx), 16'h0);
   endtask

   // Runs one sweep, checking per-cycle vector drive. stop_kind 1 = abort, 2 = reset,
   // applied on the first SETTLE cycle of vector stop_at. restart_at pulses start mid-sweep.
   // Counting the start-accept cycle as cycle 1, done is checked on cycle 16*(S+1)+1.
   task automatic sweep(input logic [15:0] exp_tab, input int stop_at, input int stop_kind,
                        input int restart_at);
      bit saw_done;
      expected = exp_tab;
      start    = 1'b1;
      step();
      start    = 1'b0;
      expected = ~exp_tab;
      for (int v = 0; v < 16; v++) begin
         for (int k = 0; k <= S; k++) begin
            if (v == stop_at && k == 0) begin
               if (stop_kind == 1) begin
                  abort = 1'b1;
                  step();
                  abort = 1'b0;
                  chk1("abort_busy", busy, 1'b0);
                  chk1("abort_en", en_out, 1'b0);
                  chk1("abort_done", done, 1'b0);
                  chk16("abort_vec", 16'(vec), 16'h0);
                  saw_done = 1'b0;
                  repeat (60) begin
                     step();
                     if (done) saw_done = 1'b1;
                  end
                  chk1("abort_no_done", saw_done, 1'b0);
               end else begin
                  #2 rst_n = 1'b0;
                  #1;
                  chk_all_zero("midsweep_reset");
                  step();
                  rst_n = 1'b1;
                  step();
                  chk1("after_reset_busy", busy, 1'b0);
               end
               return;
            end
            chk16("vec", 16'(vec), 16'(v));
            chk1("en", en_out, 1'b1);
            chk1("busy", busy, 1'b1);
            chk1("done_early", done, 1'b0);
            start = (v == restart_at && k == 0);
            step();
         end
      end
      start = 1'b0;
      chk1("done", done, 1'b1);
      chk1("done_busy", busy, 1'b0);
      chk1("done_en", en_out, 1'b0);
      step();
      chk1("done_pulse", done, 1'b0);
   endtask

   task automatic chk_results(input string tag, input logic [15:0] tab, input logic [4:0] errs,
                              input logic [3:0] first, input logic mis);
      chk16({tag, "_table"}, table_out, tab);
      chk16({tag, "_err"}, 16'(err_count), 16'(errs));
      chk16({tag, "_first"}, 16'(first_err_idx), 16'(first));
      chk1({tag, "_mismatch"}, mismatch, mis);
   endtask

   initial begin
      rst_n    = 1'b1;
      start    = 1'b0;
      abort    = 1'b0;
      expected = 16'h0;
      #2 rst_n = 1'b0;
      #1;
      chk_all_zero("reset");
      step();
      step();
      rst_n = 1'b1;
      step();
      chk_all_zero("post_reset_idle");

      mode = 1;
      sweep(16'h8000, -1, 0, -1);
      chk_results("and", 16'h8000, 5'd0, 4'd0, 1'b0);

      mode = 0;
      sweep(16'hFFFF, -1, 0, -1);
      chk_results("all_wrong", 16'h0000, 5'd16, 4'd0, 1'b1);

      mode = 3;
      sweep(16'h6996, -1, 0, -1);
      chk_results("xor_bad5", 16'h69B6, 5'd1, 4'd5, 1'b1);
      repeat (3) step();
      chk_results("hold", 16'h69B6, 5'd1, 4'd5, 1'b1);

      start = 1'b1;
      abort = 1'b1;
      step();
      start = 1'b0;
      abort = 1'b0;
      chk1("start_abort_busy", busy, 1'b0);
      chk1("start_abort_en", en_out, 1'b0);
      step();
      chk1("start_abort_stay_idle", busy, 1'b0);
      chk16("start_abort_keep_table", table_out, 16'h69B6);

      mode = 3;
      sweep(16'h6996, 7, 1, -1);
      chk_results("abort_partial", 16'h0036, 5'd1, 4'd5, 1'b0);

      mode = 1;
      sweep(16'h8000, -1, 0, 3);
      chk_results("restart_ignored", 16'h8000, 5'd0, 4'd0, 1'b0);

      mode = 2;
      sweep(16'h6996, 10, 2, -1);
      sweep(16'h6996, -1, 0, -1);
      chk_results("after_reset", 16'h6996, 5'd0, 4'd0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
